// File: rtl/synch_evt_rx.sv
// -----------------------------------------------------------------------------
// synch_evt_rx
// Receives NCH asynchronous toggle-encoded event lines into the clkS domain.
// Every level change on tog_in[i] is one event: it is synchronised, edge
// detected, strobed for one cycle, latched as pending until acknowledged,
// flagged as an overrun if it lands on an unacknowledged event, and counted
// in a saturating per-channel counter.
//
// Ports
//   clkS       receive-domain clock, all state on its rising edge
//   rst        asynchronous active-high reset
//   tog_in     asynchronous toggle inputs, one per channel
//   ack        per-channel acknowledge of a pending event (clkS domain)
//   clr        synchronous clear of all counters and overrun flags
//   evt_pulse  registered one-cycle event strobe per channel
//   evt_pend   sticky event-pending flag per channel
//   ovr        sticky overrun flag per channel
//   evt_cnt    packed saturating counters, channel i at [i*CNT_W +: CNT_W]
//   any_evt    OR of all evt_pulse bits
// -----------------------------------------------------------------------------
module synch_evt_rx #(
   parameter int unsigned NCH    = 4,
   parameter int unsigned STAGES = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                   clkS,
   input  logic                   rst,
   input  logic [NCH-1:0]         tog_in,
   input  logic [NCH-1:0]         ack,
   input  logic                   clr,
   output logic [NCH-1:0]         evt_pulse,
   output logic [NCH-1:0]         evt_pend,
   output logic [NCH-1:0]         ovr,
   output logic [NCH*CNT_W-1:0]   evt_cnt,
   output logic                   any_evt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Stage 0 is the flop that samples tog_in; stage STAGES-1 is the sync output.
   logic [STAGES-1:0][NCH-1:0] sync_q, sync_d;
   logic [NCH-1:0]             hist_q, hist_d;
   logic [NCH-1:0]             pulse_q, pulse_d;
   logic [NCH-1:0]             pend_q, pend_d;
   logic [NCH-1:0]             ovr_q, ovr_d;
   logic [NCH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [NCH-1:0]             det;

   // Edge detect between the synchronised level and its one-cycle history.
   assign det = sync_q[STAGES-1] ^ hist_q;

   // Next-state logic for all channels.
   always_comb begin : next_state
      sync_d  = {sync_q[STAGES-2:0], tog_in};
      hist_d  = sync_q[STAGES-1];
      pulse_d = det;
      // A new event keeps the flag set even when acknowledged on the same edge.
      pend_d  = det | (pend_q & ~ack);
      // Overrun set takes priority over clr so a coincident overrun is not lost.
      ovr_d   = (det & pend_q & ~ack) | (ovr_q & {NCH{~clr}});
      cnt_d   = cnt_q;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (clr) begin
            cnt_d[i] = det[i] ? CNT_ONE : '0;
         end else if (det[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // State registers; reset discards anything in the synchroniser.
   always_ff @(posedge clkS or posedge rst) begin : state_reg
      if (rst) begin
         sync_q  <= '0;
         hist_q  <= '0;
         pulse_q <= '0;
         pend_q  <= '0;
         ovr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         hist_q  <= hist_d;
         pulse_q <= pulse_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign evt_pulse = pulse_q;
   assign evt_pend  = pend_q;
   assign ovr       = ovr_q;
   assign evt_cnt   = cnt_q;
   assign any_evt   = |pulse_q;

endmodule
